// File: rtl/sha_rd_arbiter_pkg.sv
// Shared types and limits for the SHA engine read-port arbiter.
// Struct widths match the default arbiter parameters.
package sha_rd_arbiter_pkg;

    localparam int SHA_RDARB_MAX_REQ = 8;

    localparam int SHA_RD_ID_W   = 16;
    localparam int SHA_RD_ADDR_W = 64;
    localparam int SHA_RD_DATA_W = 512;

    typedef struct packed {
        logic [SHA_RD_ID_W-1:0]   id;
        logic [SHA_RD_ADDR_W-1:0] addr;
        logic [7:0]               len;
        logic [2:0]               size;
    } sha_rd_ar_t;

    typedef struct packed {
        logic [SHA_RD_ID_W-1:0]   id;
        logic [SHA_RD_DATA_W-1:0] data;
        logic [1:0]               resp;
        logic                     last;
    } sha_rd_r_t;

endpackage

// File: rtl/sha_rd_arbiter_rr.sv
// Round-robin grant: first requester at or after ptr_q wins; combinational grant, 0 cycles.
// ptr_q moves past the winner only when advance_i says the grant was taken.
module rr_arbiter
    import sha_rd_arbiter_pkg::*;
#(
    parameter int N = SHA_RDARB_MAX_REQ
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] cand;
    logic             found;

    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        cand    = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % N);
            if (!found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                found         = 1'b1;
                if (advance_i) begin
                    ptr_d = PTR_W'((int'(cand) + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sha_rd_arbiter.sv
// N_REQ SHA read masters share one AXI AR/R port; AR 1-cycle registered slice, R combinational.
// AR stalls hold the slice; R back-pressure passes straight through. Option: SHA_RDARB_LIMIT_EN.
module sha_rd_arbiter
    import sha_rd_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = $clog2(N_REQ),
    parameter int ID_W    = 16,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 512,
    parameter int MAX_OUT = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_REQ-1:0][ID_W-1:0]     arid_s,
    input  logic [N_REQ-1:0][ADDR_W-1:0]   araddr_s,
    input  logic [N_REQ-1:0][7:0]          arlen_s,
    input  logic [N_REQ-1:0][2:0]          arsize_s,
    input  logic [N_REQ-1:0]               arvalid_s,
    output logic [N_REQ-1:0]               arready_s,
    output logic [N_REQ-1:0][ID_W-1:0]     rid_s,
    output logic [N_REQ-1:0][DATA_W-1:0]   rdata_s,
    output logic [N_REQ-1:0][1:0]          rresp_s,
    output logic [N_REQ-1:0]               rlast_s,
    output logic [N_REQ-1:0]               rvalid_s,
    input  logic [N_REQ-1:0]               rready_s,
    output logic [ID_W-1:0]                arid_m,
    output logic [ADDR_W-1:0]              araddr_m,
    output logic [7:0]                     arlen_m,
    output logic [2:0]                     arsize_m,
    output logic                           arvalid_m,
    input  logic                           arready_m,
    input  logic [ID_W-1:0]                rid_m,
    input  logic [DATA_W-1:0]              rdata_m,
    input  logic [1:0]                     rresp_m,
    input  logic                           rlast_m,
    input  logic                           rvalid_m,
    output logic                           rready_m
);

    logic                 slv_q;
    logic [ID_W-1:0]      arid_q;
    logic [ADDR_W-1:0]    araddr_q;
    logic [7:0]           arlen_q;
    logic [2:0]           arsize_q;

    logic [N_REQ-1:0]     lim_mask;
    logic [N_REQ-1:0]     grant;
    logic                 can_load;
    logic                 ar_hs;
    logic [IDX_W-1:0]     sel_idx;
    logic [ID_W-1:0]      sel_id;
    logic [ADDR_W-1:0]    sel_addr;
    logic [7:0]           sel_len;
    logic [2:0]           sel_size;
    logic [IDX_W-1:0]     r_idx;
    logic                 unused_arid_top;

    assign can_load = !slv_q || arready_m;

    // Gated by rst_n so no requester sees a handshake while reset is held.
    assign arready_s = grant & {N_REQ{can_load && rst_n}};
    assign ar_hs     = |arready_s;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (arvalid_s & ~lim_mask),
        .advance_i (can_load && rst_n),
        .grant_o   (grant)
    );

    always_comb begin
        sel_idx         = '0;
        sel_id          = '0;
        sel_addr        = '0;
        sel_len         = '0;
        sel_size        = '0;
        unused_arid_top = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            unused_arid_top = unused_arid_top ^ (^arid_s[i][ID_W-1 -: IDX_W]);
            if (grant[i]) begin
                sel_idx  = IDX_W'(i);
                sel_id   = arid_s[i];
                sel_addr = araddr_s[i];
                sel_len  = arlen_s[i];
                sel_size = arsize_s[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slv_q    <= 1'b0;
            arid_q   <= '0;
            araddr_q <= '0;
            arlen_q  <= '0;
            arsize_q <= '0;
        end else if (can_load) begin
            slv_q <= ar_hs;
            if (ar_hs) begin
                arid_q   <= {sel_idx, sel_id[ID_W-IDX_W-1:0]};
                araddr_q <= sel_addr;
                arlen_q  <= sel_len;
                arsize_q <= sel_size;
            end
        end
    end

    assign arvalid_m = slv_q;
    assign arid_m    = arid_q;
    assign araddr_m  = araddr_q;
    assign arlen_m   = arlen_q;
    assign arsize_m  = arsize_q;

    // Tags beyond N_REQ match no requester and are sunk with rready_m held high.
    assign r_idx = rid_m[ID_W-1 -: IDX_W];

    always_comb begin
        rvalid_s = '0;
        rready_m = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_idx == IDX_W'(i)) begin
                rvalid_s[i] = rvalid_m;
                rready_m    = rready_s[i];
            end
        end
    end

    assign rid_s   = {N_REQ{{{IDX_W{1'b0}}, rid_m[ID_W-IDX_W-1:0]}}};
    assign rdata_s = {N_REQ{rdata_m}};
    assign rresp_s = {N_REQ{rresp_m}};
    assign rlast_s = {N_REQ{rlast_m}};

`ifdef SHA_RDARB_LIMIT_EN
    logic [N_REQ-1:0][3:0] cnt_q, cnt_d;
    logic                  inc, dec;

    always_comb begin
        cnt_d    = cnt_q;
        lim_mask = '0;
        inc      = 1'b0;
        dec      = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            inc = arready_s[i] && arvalid_s[i];
            dec = rvalid_s[i] && rready_s[i] && rlast_m && (cnt_q[i] != 4'd0);
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - 4'd1;
            end
            lim_mask[i] = (cnt_q[i] == 4'(MAX_OUT));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int UNUSED_MAX_OUT = MAX_OUT;
    assign lim_mask = '0;
`endif

endmodule

// File: tb/tb_sha_rd_arbiter.sv
// Directed bench for sha_rd_arbiter: AR fairness, stall, reset, table-driven R routing.
module tb_sha_rd_arbiter;

    logic                   clk;
    logic                   rst_n;
    logic [3:0][15:0]       arid_s;
    logic [3:0][63:0]       araddr_s;
    logic [3:0][7:0]        arlen_s;
    logic [3:0][2:0]        arsize_s;
    logic [3:0]             arvalid_s;
    logic [3:0]             arready_s;
    logic [3:0][15:0]       rid_s;
    logic [3:0][511:0]      rdata_s;
    logic [3:0][1:0]        rresp_s;
    logic [3:0]             rlast_s;
    logic [3:0]             rvalid_s;
    logic [3:0]             rready_s;
    logic [15:0]            arid_m;
    logic [63:0]            araddr_m;
    logic [7:0]             arlen_m;
    logic [2:0]             arsize_m;
    logic                   arvalid_m;
    logic                   arready_m;
    logic [15:0]            rid_m;
    logic [511:0]           rdata_m;
    logic [1:0]             rresp_m;
    logic                   rlast_m;
    logic                   rvalid_m;
    logic                   rready_m;

    int n_cmp;
    int n_bad;

    sha_rd_arbiter #(
        .N_REQ(4), .IDX_W(2), .ID_W(16), .ADDR_W(64), .DATA_W(512), .MAX_OUT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .arid_s(arid_s), .araddr_s(araddr_s), .arlen_s(arlen_s), .arsize_s(arsize_s),
        .arvalid_s(arvalid_s), .arready_s(arready_s),
        .rid_s(rid_s), .rdata_s(rdata_s), .rresp_s(rresp_s), .rlast_s(rlast_s),
        .rvalid_s(rvalid_s), .rready_s(rready_s),
        .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
        .arvalid_m(arvalid_m), .arready_m(arready_m),
        .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
        .rvalid_m(rvalid_m), .rready_m(rready_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rvalid;
        logic [15:0] rid;
        logic [3:0]  rready;
        logic [3:0]  exp_rvalid_s;
        logic        exp_rready_m;
        logic [15:0] exp_rid_s;
    } r_vec_t;

    r_vec_t rvec [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        rvec[0] = '{1'b1, 16'h4003, 4'b1101, 4'b0010, 1'b0, 16'h0003};
        rvec[1] = '{1'b1, 16'h4003, 4'b0010, 4'b0010, 1'b1, 16'h0003};
        rvec[2] = '{1'b1, 16'hC0FF, 4'b0111, 4'b1000, 1'b0, 16'h00FF};
        rvec[3] = '{1'b0, 16'h8001, 4'b1111, 4'b0000, 1'b1, 16'h0001};
        rvec[4] = '{1'b1, 16'h0ABC, 4'b0001, 4'b0001, 1'b1, 16'h0ABC};
        rvec[5] = '{1'b1, 16'h3FFF, 4'b1110, 4'b0001, 1'b0, 16'h3FFF};

        rst_n     = 1'b0;
        arready_m = 1'b0;
        arvalid_s = 4'b1111;
        rvalid_m  = 1'b0;
        rid_m     = '0;
        rdata_m   = '0;
        rresp_m   = '0;
        rlast_m   = 1'b0;
        rready_s  = '0;
        for (int i = 0; i < 4; i++) begin
            arid_s[i]   = 16'(16'h0010 + i);
            araddr_s[i] = 64'(64'h1_0000 * (i + 1));
            arlen_s[i]  = 8'(i + 1);
            arsize_s[i] = 3'd6;
        end

        settle();
        chk("reset_arvalid_m", 64'(arvalid_m), 64'h0);
        chk("reset_arid_m", 64'(arid_m), 64'h0);
        chk("reset_araddr_m", araddr_m, 64'h0);
        chk("reset_arready_s", 64'(arready_s), 64'h0);
        tick();
        tick();
        chk("reset_hold_arready_s", 64'(arready_s), 64'h0);

        // Fairness: all four requesting, downstream always ready.
        rst_n     = 1'b1;
        arready_m = 1'b1;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk($sformatf("fair_grant_%0d", c), 64'(arready_s), 64'(4'b0001 << (c % 4)));
            tick();
            chk($sformatf("fair_vld_%0d", c), 64'(arvalid_m), 64'h1);
            chk($sformatf("fair_id_%0d", c), 64'(arid_m),
                64'(((c % 4) << 14) | (16'h0010 + (c % 4))));
        end
        arvalid_s = 4'b0000;

        // Single requester 2.
        arvalid_s   = 4'b0100;
        arid_s[2]   = 16'h0005;
        araddr_s[2] = 64'h1000;
        arlen_s[2]  = 8'd3;
        settle();
        chk("single_grant", 64'(arready_s), 64'b0100);
        tick();
        arvalid_s = 4'b0000;
        chk("single_vld", 64'(arvalid_m), 64'h1);
        chk("single_id", 64'(arid_m), 64'h8005);
        chk("single_addr", araddr_m, 64'h1000);
        chk("single_len", 64'(arlen_m), 64'h3);
        tick();
        chk("single_drain", 64'(arvalid_m), 64'h0);

        // Back-pressure: pointer sits at 3, so requester 3 fills the slice.
        for (int i = 0; i < 4; i++) begin
            arid_s[i]   = 16'(16'h0020 + i);
            araddr_s[i] = 64'(64'h100 * (i + 1));
        end
        arready_m = 1'b0;
        arvalid_s = 4'b1111;
        settle();
        chk("bp_first_grant", 64'(arready_s), 64'b1000);
        tick();
        for (int c = 0; c < 5; c++) begin
            settle();
            chk($sformatf("bp_vld_%0d", c), 64'(arvalid_m), 64'h1);
            chk($sformatf("bp_id_%0d", c), 64'(arid_m), 64'hC023);
            chk($sformatf("bp_addr_%0d", c), araddr_m, 64'h400);
            chk($sformatf("bp_rdy_%0d", c), 64'(arready_s), 64'h0);
            tick();
        end
        arready_m = 1'b1;
        settle();
        chk("bp_release_grant", 64'(arready_s), 64'b0001);
        tick();
        chk("bp_next_id", 64'(arid_m), 64'h0020);
        chk("bp_next_addr", araddr_m, 64'h100);

        // Reset with the slice full and pointer at 1.
        arready_m = 1'b0;
        rst_n     = 1'b0;
        settle();
        chk("mid_rst_arvalid_m", 64'(arvalid_m), 64'h0);
        chk("mid_rst_arid_m", 64'(arid_m), 64'h0);
        chk("mid_rst_arready_s", 64'(arready_s), 64'h0);
        tick();
        rst_n     = 1'b1;
        arready_m = 1'b1;
        settle();
        chk("post_rst_grant", 64'(arready_s), 64'b0001);
        tick();
        arvalid_s = 4'b0000;
        chk("post_rst_id", 64'(arid_m), 64'h0020);

        // R routing table.
        rresp_m = 2'b10;
        rlast_m = 1'b1;
        for (int v = 0; v < 6; v++) begin
            rvalid_m = rvec[v].rvalid;
            rid_m    = rvec[v].rid;
            rready_s = rvec[v].rready;
            rdata_m  = {8{64'(64'hA5A5_0000_0000_0000 + v)}};
            settle();
            chk($sformatf("r_rvalid_s_%0d", v), 64'(rvalid_s), 64'(rvec[v].exp_rvalid_s));
            chk($sformatf("r_rready_m_%0d", v), 64'(rready_m), 64'(rvec[v].exp_rready_m));
            chk($sformatf("r_rid_s_%0d", v), 64'(rid_s[1]), 64'(rvec[v].exp_rid_s));
            chk($sformatf("r_rdata_%0d", v), rdata_s[3][63:0], 64'(64'hA5A5_0000_0000_0000 + v));
        end
        chk("r_resp_fanout", 64'(rresp_s[2]), 64'h2);
        chk("r_last_fanout", 64'(rlast_s), 64'hF);
        rvalid_m = 1'b0;
        rlast_m  = 1'b0;
        rready_s = '0;
        tick();

`ifdef SHA_RDARB_LIMIT_EN
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        arready_m = 1'b1;
        arvalid_s = 4'b0001;
        settle();
        chk("lim_ar0", 64'(arready_s), 64'b0001);
        tick();
        settle();
        chk("lim_ar1", 64'(arready_s), 64'b0001);
        tick();
        settle();
        chk("lim_ar2_stall", 64'(arready_s), 64'b0000);
        arvalid_s = 4'b1111;
        settle();
        chk("lim_others_served", 64'(arready_s), 64'b0010);
        tick();
        arvalid_s = 4'b0001;
        rvalid_m  = 1'b1;
        rid_m     = 16'h0000;
        rlast_m   = 1'b1;
        rready_s  = 4'b1111;
        settle();
        chk("lim_still_masked", 64'(arready_s), 64'b0000);
        tick();
        rvalid_m = 1'b0;
        rlast_m  = 1'b0;
        settle();
        chk("lim_unmasked", 64'(arready_s), 64'b0001);
        arvalid_s = 4'b0000;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
